// File: rtl/decode_operand_stage.sv
// decode_operand_stage
//   Decode stage sitting in front of a register file that has a one-cycle
//   registered read. It accepts an instruction and its PC, drives the RF read
//   addresses, and decodes the immediate and control fields. On the following
//   cycle it combines the RF read data with writeback bypass and x0 zeroing.
//   The resulting operand bundle goes to execute over a valid/ready handshake.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           fetch handshake
//   in_instr, in_pc             instruction word and its PC
//   rf_rs1_addr/rf_rs2_addr     register file read addresses
//   rf_rs1_data/rf_rs2_data     register file read data (one cycle after addr)
//   wb_en, wb_rd, wb_data       writeback port (same write the RF sees)
//   out_valid/out_ready         execute handshake
//   out_pc .. out_illegal       decoded operand bundle
module decode_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;  // no bundle
  localparam logic [1:0] ST_READ  = 2'd1;  // RF data arriving this cycle
  localparam logic [1:0] ST_HOLD  = 2'd2;  // stalled, operands in hold regs

  logic [1:0]      state_q, state_d;
  logic            accept;

  logic [XLEN-1:0] pc_q, imm_q;
  logic [4:0]      rd_q;
  logic [6:0]      opcode_q;
  logic [2:0]      funct3_q;
  logic            funct7b5_q, illegal_q;

  logic [31:0]     imm32_d;
  logic            illegal_d;

  // Per-source views, index 0 = rs1, index 1 = rs2.
  logic [1:0][4:0]      src_addr_in;
  logic [1:0][4:0]      src_addr_rf;
  logic [1:0][XLEN-1:0] src_rf_data;
  logic [1:0][XLEN-1:0] src_val;

  assign in_ready  = (state_q == ST_EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q != ST_EMPTY);

  assign src_addr_in[0] = in_instr[19:15];
  assign src_addr_in[1] = in_instr[24:20];
  assign src_rf_data[0] = rf_rs1_data;
  assign src_rf_data[1] = rf_rs2_data;

  assign rf_rs1_addr = src_addr_rf[0];
  assign rf_rs2_addr = src_addr_rf[1];
  assign out_rs1_val = src_val[0];
  assign out_rs2_val = src_val[1];

  assign out_pc       = pc_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_opcode   = opcode_q;
  assign out_funct3   = funct3_q;
  assign out_funct7b5 = funct7b5_q;
  assign out_illegal  = illegal_q;

  // Immediate decode happens at accept time. All fields are then registered,
  // so they stay put for the whole time the bundle waits.
  always_comb begin
    imm32_d   = '0;
    illegal_d = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm32_d = {{20{in_instr[31]}}, in_instr[31:20]};
      7'b0100011:
        imm32_d = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      7'b1100011:
        imm32_d = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32_d = {in_instr[31:12], 12'b0};
      7'b1101111:
        imm32_d = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      7'b0110011:
        imm32_d = '0;
      default:
        illegal_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: state_d = accept ? ST_READ : ST_EMPTY;
      ST_READ, ST_HOLD: begin
        if (out_ready) state_d = accept ? ST_READ : ST_EMPTY;
        else           state_d = ST_HOLD;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      pc_q       <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q       <= in_pc;
        imm_q      <= XLEN'($signed(imm32_d));
        rd_q       <= in_instr[11:7];
        opcode_q   <= in_instr[6:0];
        funct3_q   <= in_instr[14:12];
        funct7b5_q <= in_instr[30];
        illegal_q  <= illegal_d;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic [4:0]      rs_q;
      logic            rec_hit_q;   // writeback hit this source in accept cycle
      logic [XLEN-1:0] rec_data_q;
      logic [XLEN-1:0] hold_q;
      logic            live_hit;
      logic [XLEN-1:0] resolved;

      assign live_hit = wb_en & (wb_rd == rs_q);

      // The RF read issued in the accept cycle misses a write made in that
      // same cycle. The recorded hit covers that case. A live writeback
      // always wins because it is the newest value.
      always_comb begin
        resolved = hold_q;
        if (rs_q == 5'd0)
          resolved = '0;
        else if (live_hit)
          resolved = wb_data;
        else if (state_q == ST_READ)
          resolved = rec_hit_q ? rec_data_q : src_rf_data[gi];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rs_q       <= '0;
          rec_hit_q  <= 1'b0;
          rec_data_q <= '0;
          hold_q     <= '0;
        end else begin
          if (accept) begin
            rs_q       <= src_addr_in[gi];
            rec_hit_q  <= wb_en & (wb_rd == src_addr_in[gi]) & (src_addr_in[gi] != 5'd0);
            rec_data_q <= wb_data;
          end
          // Tracking the resolved value every valid cycle covers two cases:
          // it is the stall copy in HOLD, and the retained value once EMPTY.
          if (state_q != ST_EMPTY)
            hold_q <= resolved;
        end
      end

      assign src_addr_rf[gi] = accept ? src_addr_in[gi] : rs_q;
      assign src_val[gi]     = (state_q == ST_EMPTY) ? hold_q : resolved;
    end
  endgenerate

endmodule

// File: tb/tb_decode_operand_stage.sv
module tb_decode_operand_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7b5, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  // Register file: registered read that returns the old value on a same-cycle write.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (wb_en) rf[wb_rd] <= wb_data;
    rf_rs1_data <= rf[rf_rs1_addr];
    rf_rs2_data <= rf[rf_rs2_addr];
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic bit ref_legal(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return op inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
  endfunction

  // Immediate reference built with arithmetic shifts and masks.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int signed s;
    logic [6:0] op;
    s  = $signed(ins);
    op = ins[6:0];
    case (op)
      7'h03, 7'h13, 7'h67: return 32'(s >>> 20);
      7'h23: return (32'(s >>> 20) & ~32'h1f) | ((ins >> 7) & 32'h1f);
      7'h63: return (ins[31] ? 32'hFFFFF000 : 32'h0) | (((ins >> 7) & 32'h1) << 11)
                  | (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
      7'h37, 7'h17: return ins & 32'hFFFFF000;
      7'h6F: return (ins[31] ? 32'hFFF00000 : 32'h0) | (((ins >> 12) & 32'hff) << 12)
                  | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t build_exp(input logic [31:0] ins, input logic [31:0] pc,
                                     input bit use_imm, input logic [31:0] imm);
    exp_t e;
    e.pc  = pc;
    e.imm = use_imm ? imm : ref_imm(ins);
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.op  = ins[6:0];
    e.f3  = ins[14:12];
    e.f7  = ins[30];
    e.ill = !ref_legal(ins);
    return e;
  endfunction

  // Present one instruction until accepted; returns at posedge+1 after accept.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input bit use_imm, input logic [31:0] imm);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept within 50 cycles");
    end else begin
      exp_q.push_back(build_exp(ins, pc, use_imm, imm));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (wb_en && wb_rd == rs) return wb_data;
    return rf[rs];
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    bit   acc_prev;
    bit   stall_prev;
    exp_t snap;
    exp_t e;
    acc_prev = 0;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        acc_prev = 0;
        stall_prev = 0;
      end else begin
        if (acc_prev) chk("latency_valid", 32'(out_valid), 32'h1);
        if (stall_prev && out_valid) begin
          chk("stable_pc", out_pc, snap.pc);
          chk("stable_imm", out_imm, snap.imm);
          chk("stable_rd", 32'(out_rd), 32'(snap.rd));
          chk("stable_opcode", 32'(out_opcode), 32'(snap.op));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bundle: got pc 0x%08h expected no bundle", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("pc", out_pc, e.pc);
            chk("imm", out_imm, e.imm);
            chk("rd", 32'(out_rd), 32'(e.rd));
            chk("opcode", 32'(out_opcode), 32'(e.op));
            chk("funct3", 32'(out_funct3), 32'(e.f3));
            chk("funct7b5", 32'(out_funct7b5), 32'(e.f7));
            chk("illegal", 32'(out_illegal), 32'(e.ill));
            chk("rs1_val", out_rs1_val, ref_operand(e.rs1));
            chk("rs2_val", out_rs2_val, ref_operand(e.rs2));
            $display("bundle pc=0x%08h op=0x%02h rs1=0x%08h rs2=0x%08h imm=0x%08h ill=%0d",
                     out_pc, out_opcode, out_rs1_val, out_rs2_val, out_imm, out_illegal);
          end
        end
        stall_prev = out_valid && !out_ready;
        snap.pc  = out_pc;
        snap.imm = out_imm;
        snap.rd  = out_rd;
        snap.op  = out_opcode;
        acc_prev = in_valid && in_ready;
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  op;
    case ($urandom_range(0, 10))
      0: op = 7'h03;  1: op = 7'h13;  2: op = 7'h67;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
      8: op = 7'h33;  9: op = 7'h7F;  default: op = 7'h0B;
    endcase
    ins = $urandom;
    ins[6:0]   = op;
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    bit pending;
    int n;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset.
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_out_imm", out_imm, 32'h0);
    chk("reset_out_illegal", 32'(out_illegal), 32'h0);
    chk("reset_out_pc", out_pc, 32'h0);
    chk("reset_rs1_val", out_rs1_val, 32'h0);
    chk("reset_rf_addr", 32'(rf_rs1_addr), 32'h0);

    // Preload the register file through the writeback port.
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      wb_en = 1'b1; wb_rd = 5'(i); wb_data = $urandom;
    end
    @(posedge clk); #1; wb_rd = 5'd5; wb_data = 32'h11;
    @(posedge clk); #1; wb_rd = 5'd6; wb_data = 32'h22;
    @(posedge clk); #1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    @(posedge clk); #1; wb_en = 1'b0;

    // add x7,x5,x6 and addi x1,x0,-1.
    out_ready = 1'b1;
    send(32'h006283B3, 32'h100, 1, 32'h0);
    send(32'hFFF00093, 32'h104, 1, 32'hFFFFFFFF);
    // Same-cycle write on accept, then live write during the read cycle.
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h99;
    send(32'h006283B3, 32'h108, 1, 32'h0);
    wb_en = 1'b0;
    send(32'h006283B3, 32'h10C, 1, 32'h0);
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h77;
    @(posedge clk); #1; wb_en = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Stall for three cycles with a writeback to x5 during the second.
    out_ready = 1'b0;
    send(32'h006283B3, 32'h200, 1, 32'h0);
    @(negedge clk); chk("stall_in_ready_1", 32'(in_ready), 32'h0);
    @(posedge clk); #1; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    @(negedge clk); chk("stall_in_ready_2", 32'(in_ready), 32'h0);
    @(posedge clk); #1; wb_en = 1'b0;
    @(negedge clk); chk("stall_in_ready_3", 32'(in_ready), 32'h0);
    chk("stall_rs1_updated", out_rs1_val, 32'h55);
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Back-to-back immediates: beq -4, sw -8, lui, jal -16, illegal opcode.
    send(32'hFE628EE3, 32'h300, 1, 32'hFFFFFFFC);
    send(32'hFE532C23, 32'h304, 1, 32'hFFFFFFF8);
    send(32'h123451B7, 32'h308, 1, 32'h12345000);
    send(32'hFF1FF0EF, 32'h30C, 1, 32'hFFFFFFF0);
    send(32'h0000007F, 32'h310, 1, 32'h0);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset while a bundle is in the READ state.
    out_ready = 1'b0;
    send(32'h006283B3, 32'h400, 1, 32'h0);
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    #2 reset = 1'b1;
    #1 chk("async_reset_valid", 32'(out_valid), 32'h0);
    @(negedge clk); #2 reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); chk("post_reset_valid", 32'(out_valid), 32'h0);
    chk("post_reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and writebacks.
    pending = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1;
        in_instr = rand_instr();
        in_pc = $urandom;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 1) != 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(build_exp(in_instr, in_pc, 0, 32'h0));
        pending = 0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;

    // Drain.
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Decode stage that sits directly upstream of the register file and consumes its outputs one cycle later.
- Accepts a fetched instruction and PC, splits out rs1/rs2/rd, and drives the register-file read addresses.
- Regenerates the sign-extended immediate and aligns it with the register file's one-cycle registered read data.
- Applies writeback bypass and x0 zeroing, then presents a complete operand bundle to execute over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rf_rs1_addr  out  5  to register file Addr1
- rf_rs2_addr  out  5  to register file Addr2
- rf_rs1_data  in  XLEN  from register file baseAddr (registered read)
- rf_rs2_data  in  XLEN  from register file writeData (registered read)
- wb_en  in  1  writeback writing this cycle (same signal as the RF regWrite)
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  PC of bundle
- out_rs1_val  out  XLEN  resolved rs1 operand
- out_rs2_val  out  XLEN  resolved rs2 operand
- out_imm  out  XLEN  sign-extended immediate
- out_rd  out  5  destination register
- out_opcode  out  7  opcode
- out_funct3  out  3  funct3
- out_funct7b5  out  1  instr[30]
- out_illegal  out  1  opcode not in supported set

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- States:
  - EMPTY: no bundle.
  - READ: register-file data arriving this cycle.
  - HOLD: bundle stalled; operands held in local registers.
- Reset: state=EMPTY. out_valid=0. All out_* data and internal latches = 0. rf_rs*_addr = 0.
- Reset asserted mid-operation drops any in-flight bundle. No output is produced for it.
- in_ready = (state==EMPTY) | out_ready. Accept = in_valid & in_ready.
- On accept:
  - Latch instr and pc.
  - Drive rf_rs1_addr/rf_rs2_addr combinationally from in_instr[19:15]/[24:20].
  - Otherwise drive them from the latched instr.
- Latency: exactly 1 cycle from accept to out_valid=1. Throughput is 1 per cycle when out_ready is held high.
- Transitions:
  - EMPTY or READ/HOLD with out_ready: accept -> READ; no accept -> EMPTY.
  - READ with !out_ready -> HOLD. Capture the resolved operands into hold registers.
  - HOLD with !out_ready -> HOLD.
- Bypass, read-cycle stale write: the register file returns the old value when written in the same cycle it is addressed.
  - On accept, record per source: match = wb_en & wb_rd==rs & rs!=0, plus wb_data.
- Operand priority, READ state, highest first:
  - rs==0 -> 0. The register file does not hard-wire x0.
  - Live match (wb_en & wb_rd==rs) -> wb_data.
  - Recorded match -> recorded data.
  - Otherwise rf_rs*_data.
- Operand priority, HOLD state:
  - rs==0 -> 0.
  - Live match -> wb_data.
  - Otherwise hold register.
  - Each cycle a live match also updates the hold register.
- Immediate, by opcode:
  - I (0000011, 0010011, 1100111): instr[31:20] sign-extended.
  - S (0100011): {instr[31:25], instr[11:7]} sign-extended.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - R (0110011) and all others: 0.
- out_illegal = 1 for opcodes outside {R, I, S, B, U, J listed above}. The bundle is still delivered normally.
- All out_* fields are stable while out_valid & !out_ready. They change only after a handshake or reset.
- When out_valid=0, data outputs hold their last value. Consumers must ignore them.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, out_imm=0. Async reset pulse mid-READ -> out_valid drops immediately.
- RF preloaded x5=0x11, x6=0x22. Accept add x7,x5,x6 (0x006283B3), out_ready=1 -> next cycle out_valid=1, rs1=0x11, rs2=0x22, rd=7, imm=0.
- Accept addi x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF, rs1=0 even if RF entry 0 was written with 0xDEAD.
- Same-cycle write on accept: wb x5=0x99 in the accept cycle -> out_rs1_val=0x99, not stale 0x11. Live wb x6=0x77 in the READ cycle -> rs2=0x77.
- out_ready=0 for 3 cycles with wb x5=0x55 in cycle 2 -> in_ready=0 throughout, bundle fields stable, rs1 becomes 0x55. Released on handshake.
- Back-to-back beq (0xFE628EE3), sw, lui, jal with out_ready=1 -> one bundle per cycle, immediates -4, correct S offset, 0xXXXXX000, correct J offset. Opcode 0x7F -> out_illegal=1.
